posit_alu_arbiter: RTL and testbench
====================================

Name: posit_alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one posit add unit between NREQ requesters.
- Each request carries two posits and an add/sub select. The block handles subtract by two's-complement negating b before issue, then drives the shared adder's a/b inputs.
- It waits a fixed ALU_LAT cycles, captures the result, and returns it to the winning requester over a valid/ready response handshake.
- It sits between the core's execute-stage requesters and a single posit adder instance (WIDTH=7, EN=1 configuration).

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 7, posit width in bits.
- ALU_LAT, 2, shared adder latency in cycles, from alu_a/alu_b stable to alu_q valid (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b; same packing as req_a.
- req_sub  in  NREQ  1 = compute a-b, 0 = compute a+b.
- resp_valid  out  NREQ  result valid, one-hot to the owning requester.
- resp_ready  in  NREQ  per-requester result accept.
- resp_q  out  WIDTH  result posit, shared by all requesters.
- alu_a  out  WIDTH  to shared adder.
- alu_b  out  WIDTH  to shared adder, already negated for subtract.
- alu_q  in  WIDTH  from shared adder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- **Reset** (rst=1 at clk edge): state=IDLE, rr_ptr=NREQ-1, alu_a=alu_b=0, resp_q=0, resp_valid=0, owner id=0, latency counter=0. req_ready is forced 0 combinationally while rst=1. A reset mid-transaction drops that transaction silently; no response is ever produced for it.
- **IDLE**:
  - The winner is the first requester with req_valid=1, searching from rr_ptr+1 and wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally; all other bits are 0. If no request is valid, req_ready=0 and the state is unchanged.
  - On the edge where req_valid&req_ready:
    - alu_a <= req_a[w].
    - alu_b <= req_sub[w] ? (~req_b[w]+1) mod 2^WIDTH : req_b[w].
    - owner <= w; rr_ptr <= w; cnt <= ALU_LAT-1; go to BUSY.
  - Negation boundaries: 0 negates to 0, and NaR (1 followed by zeros) negates to itself. Both are required, not special-cased.
- **BUSY**:
  - alu_a and alu_b are held stable. req_ready=0.
  - cnt decrements each cycle. On the cycle cnt==0: resp_q <= alu_q, resp_valid[owner] <= 1, go to RESP.
  - The first response is visible ALU_LAT+1 cycles after the accept edge.
- **RESP**:
  - resp_valid[owner] and resp_q are held until resp_ready[owner]=1 at a clk edge.
  - On that edge: resp_valid <= 0 and go to IDLE.
  - resp_ready on non-owner lines is ignored. req_ready=0 throughout.
  - Minimum spacing between accepts is ALU_LAT+2 cycles.
- **Starvation and priority**:
  - With all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
  - A requester that deasserts req_valid before it is granted is skipped; no state is kept for it.
- **Stability**: requester inputs are sampled only on the accept edge. Later changes do not affect the transaction in flight.
- **Simultaneous events**: a new req_valid arriving in the same cycle as the RESP handshake completes is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: POSIT_ARB_PERF_EN.
- **Defined**:
  - Adds output port perf_grants, NREQ*16 bits, one 16-bit counter per requester.
  - A requester's counter increments on each accept edge for that requester and saturates at 0xFFFF.
  - All counters clear on rst.
- **Undefined**: the port, counters and logic are absent. Behaviour is otherwise identical.

Test Plan:
- **Single add**: rst 2 cycles; req0 a=0x20 (1.0), b=0x20, sub=0; model alu_q=0x28 after ALU_LAT=2.
  - Required: req_ready[0]=1 in IDLE; alu_a=0x20, alu_b=0x20; resp_valid[0]=1 with resp_q=0x28 exactly 3 cycles after accept.
- **Subtract negation**: req1 a=0x20, b=0x20, sub=1.
  - Required: alu_b=0x60; with model alu_q=0x00, resp_q=0x00.
  - Also: b=0x00, sub=1 gives alu_b=0x00; b=0x40 (NaR), sub=1 gives alu_b=0x40.
- **Round-robin**: all four req_valid held high, resp_ready high.
  - Required: accept order 0,1,2,3,0; no requester is granted twice before the others; accepts spaced ALU_LAT+2=4 cycles.
- **Response backpressure**: resp_ready[2]=0 for 5 cycles after resp_valid[2] rises.
  - Required: resp_valid[2] and resp_q are held constant; req_ready stays 0; accept happens the cycle after resp_ready[2]=1 is sampled.
  - Required: resp_ready[0]=1 during the hold has no effect.
- **Reset mid-operation**: assert rst while in BUSY.
  - Required: next cycle busy=0, resp_valid=0, alu_a=alu_b=0; with req0 and req3 valid after reset, req0 is granted first.
- **Perf counters** (POSIT_ARB_PERF_EN): grant req1 three times.
  - Required: perf_grants[31:16]=3, all other counters 0.
  - Required: a counter preloaded near saturation via 65,540 grants reads 0xFFFF.

Source files
------------

// File: rtl/posit_alu_arbiter.sv
// posit_alu_arbiter
//   Round-robin arbiter that shares one posit adder between NREQ requesters.
//   A granted request has its operands registered onto alu_a/alu_b (b is
//   two's-complement negated for subtract). The block then waits ALU_LAT
//   cycles, captures alu_q, and returns it on a valid/ready response.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     req_valid/req_ready per-requester request handshake (ready one-hot/zero)
//     req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//     req_sub             1 = a-b, 0 = a+b
//     resp_valid/ready    per-requester response handshake (valid one-hot)
//     resp_q              shared result posit
//     alu_a, alu_b, alu_q shared adder interface
//     busy                high whenever not IDLE
//     perf_grants         per-requester 16-bit saturating grant counters
//                         (only when POSIT_ARB_PERF_EN is defined)
//
//   state | meaning
//   IDLE  | searching for a winner from rr_ptr+1, req_ready driven
//   BUSY  | operands held on the adder, counting down ALU_LAT cycles
//   RESP  | result held on resp_q until the owner accepts it
module posit_alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 7,
    parameter int ALU_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_sub,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]        resp_q,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    input  logic [WIDTH-1:0]        alu_q,
    output logic                    busy
`ifdef POSIT_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]      perf_grants
`endif
);

    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   owner;
    logic [CNT_W-1:0] cnt;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_b_neg;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign sel_a     = req_a[win_id*WIDTH +: WIDTH];
    assign sel_b     = req_b[win_id*WIDTH +: WIDTH];
    // Plain two's complement: 0 and NaR both map to themselves naturally.
    assign sel_b_neg = ~sel_b + WIDTH'(1);

    assign req_ready = (!rst && state == IDLE && win_found) ? (NREQ'(1) << win_id) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= IDW'(NREQ - 1);
            owner      <= '0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_q     <= '0;
            resp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        alu_a  <= sel_a;
                        alu_b  <= req_sub[win_id] ? sel_b_neg : sel_b;
                        owner  <= win_id;
                        rr_ptr <= win_id;
                        cnt    <= CNT_W'(ALU_LAT - 1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        resp_q     <= alu_q;
                        resp_valid <= NREQ'(1) << owner;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POSIT_ARB_PERF_EN
    logic [15:0] perf_cnt [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) perf_cnt[i] <= '0;
        end else if (state == IDLE && win_found && perf_cnt[win_id] != 16'hFFFF) begin
            perf_cnt[win_id] <= perf_cnt[win_id] + 16'd1;
        end
    end

    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < NREQ; i++) perf_grants[i*16 +: 16] = perf_cnt[i];
    end
`endif

endmodule

// File: tb/tb_posit_alu_arbiter.sv
// Testbench for posit_alu_arbiter. A stand-in adder drives alu_q one
// register stage after alu_a/alu_b, so the value is correct only once the
// operands have been stable for ALU_LAT cycles.
module tb_posit_alu_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 7;
    localparam int ALU_LAT = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_sub = '0;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready = '0;
    logic [WIDTH-1:0]      resp_q;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [WIDTH-1:0]      alu_q = '0;
    logic                  busy;
`ifdef POSIT_ARB_PERF_EN
    logic [NREQ*16-1:0]    perf_grants;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    posit_alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_q(resp_q),
        .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q),
        .busy(busy)
`ifdef POSIT_ARB_PERF_EN
        , .perf_grants(perf_grants)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in adder: exact for 1.0+1.0 and x+(-x); arbitrary but
    // deterministic otherwise.
    function automatic logic [WIDTH-1:0] fake_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (((int'(a) + int'(b)) % 128) == 0) return 7'h00;
        if (a == 7'h20 && b == 7'h20) return 7'h28;
        return 7'(((int'(a) * 3) + int'(b)) ^ 'h15);
    endfunction

    function automatic logic [WIDTH-1:0] model_neg(input logic [WIDTH-1:0] b);
        return 7'((128 - int'(b)) % 128);
    endfunction

    always @(posedge clk) alu_q <= fake_add(alu_a, alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid == '0 && n < 20) begin
            tick();
            n++;
        end
        if (resp_valid == '0) n = 99;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || resp_valid !== '0) begin
            $display("FAIL reset_state: busy=%b resp_valid=%b want 0/0", busy, resp_valid);
            tests_failed++;
        end
        tests_run++;
        if (alu_a !== '0 || alu_b !== '0 || resp_q !== '0) begin
            $display("FAIL reset_regs: alu_a=%h alu_b=%h resp_q=%h want 0", alu_a, alu_b, resp_q);
            tests_failed++;
        end
        tests_run++;
        if (req_ready !== '0) begin
            $display("FAIL reset_ready: got %b want 0000", req_ready);
            tests_failed++;
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        int n;
        req_a[0 +: WIDTH] = 7'h20;
        req_b[0 +: WIDTH] = 7'h20;
        req_sub[0] = 1'b0;
        req_valid = 4'b0001;
        resp_ready = '0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL single_ready: got %b want 0001", req_ready);
            tests_failed++;
        end
        tick();
        req_valid = '0;
        tests_run++;
        if (alu_a !== 7'h20 || alu_b !== 7'h20) begin
            $display("FAIL single_operands: alu_a=%h alu_b=%h want 20/20", alu_a, alu_b);
            tests_failed++;
        end
        wait_resp(n);
        tests_run++;
        if (n + 1 !== ALU_LAT + 1) begin
            $display("FAIL single_latency: got %0d want %0d", n + 1, ALU_LAT + 1);
            tests_failed++;
        end
        tests_run++;
        if (resp_valid !== 4'b0001 || resp_q !== 7'h28) begin
            $display("FAIL single_result: valid=%b q=%h want 0001/28", resp_valid, resp_q);
            tests_failed++;
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        tests_run++;
        if (resp_valid !== '0 || busy !== 1'b0) begin
            $display("FAIL single_release: valid=%b busy=%b want 0000/0", resp_valid, busy);
            tests_failed++;
        end
    endtask

    task automatic test_sub_negation();
        logic [WIDTH-1:0] b_tab [3];
        logic [WIDTH-1:0] nb_tab[3];
        int n;
        b_tab[0] = 7'h20; nb_tab[0] = 7'h60;
        b_tab[1] = 7'h00; nb_tab[1] = 7'h00;
        b_tab[2] = 7'h40; nb_tab[2] = 7'h40;
        for (int c = 0; c < 3; c++) begin
            req_a[1*WIDTH +: WIDTH] = 7'h20;
            req_b[1*WIDTH +: WIDTH] = b_tab[c];
            req_sub[1] = 1'b1;
            req_valid = 4'b0010;
            #1;
            tests_run++;
            if (req_ready !== 4'b0010) begin
                $display("FAIL sub_ready[%0d]: got %b want 0010", c, req_ready);
                tests_failed++;
            end
            tick();
            req_valid = '0;
            tests_run++;
            if (alu_b !== nb_tab[c]) begin
                $display("FAIL sub_alu_b[%0d]: got %h want %h", c, alu_b, nb_tab[c]);
                tests_failed++;
            end
            wait_resp(n);
            tests_run++;
            if (resp_valid !== 4'b0010 || resp_q !== fake_add(7'h20, nb_tab[c])) begin
                $display("FAIL sub_result[%0d]: valid=%b q=%h want 0010/%h", c, resp_valid, resp_q,
                         fake_add(7'h20, nb_tab[c]));
                tests_failed++;
            end
            resp_ready = 4'b0010;
            tick();
            resp_ready = '0;
        end
        req_sub[1] = 1'b0;
    endtask

    task automatic test_round_robin();
        int ids[$];
        int cyc[$];
        int c;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 7'($urandom);
            req_b[i*WIDTH +: WIDTH] = 7'($urandom);
        end
        req_valid  = '1;
        resp_ready = '1;
        c = 0;
        #1;
        while (ids.size() < 5 && c < 60) begin
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) begin
                    ids.push_back(i);
                    cyc.push_back(c);
                end
            tick();
            c++;
        end
        req_valid = '0;
        tests_run++;
        if (ids.size() !== 5) begin
            $display("FAIL rr_count: got %0d accepts want 5", ids.size());
            tests_failed++;
        end
        for (int k = 0; k < ids.size(); k++) begin
            tests_run++;
            if (ids[k] !== (k % NREQ)) begin
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, ids[k], k % NREQ);
                tests_failed++;
            end
            if (k > 0) begin
                tests_run++;
                if (cyc[k] - cyc[k-1] !== ALU_LAT + 2) begin
                    $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, cyc[k] - cyc[k-1], ALU_LAT + 2);
                    tests_failed++;
                end
            end
        end
        wait_idle();
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a2, b2, a0, exp_q;
        int n;
        a2 = 7'($urandom);
        b2 = 7'($urandom);
        a0 = 7'($urandom);
        req_a[2*WIDTH +: WIDTH] = a2;
        req_b[2*WIDTH +: WIDTH] = b2;
        req_sub[2] = 1'b1;
        req_a[0 +: WIDTH] = a0;
        req_sub[0] = 1'b0;
        exp_q = fake_add(a2, model_neg(b2));
        req_valid = 4'b0100;
        resp_ready = '0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL bp_ready: got %b want 0100", req_ready);
            tests_failed++;
        end
        tick();
        req_valid = 4'b0101;
        wait_resp(n);
        tests_run++;
        if (resp_valid !== 4'b0100 || resp_q !== exp_q) begin
            $display("FAIL bp_result: valid=%b q=%h want 0100/%h", resp_valid, resp_q, exp_q);
            tests_failed++;
        end
        for (int k = 0; k < 5; k++) begin
            resp_ready = 4'b0001;
            tick();
            tests_run++;
            if (resp_valid !== 4'b0100 || resp_q !== exp_q || req_ready !== '0) begin
                $display("FAIL bp_hold[%0d]: valid=%b q=%h ready=%b want 0100/%h/0000", k, resp_valid,
                         resp_q, req_ready, exp_q);
                tests_failed++;
            end
        end
        resp_ready = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== '0) begin
            $display("FAIL bp_handshake_ready: got %b want 0000", req_ready);
            tests_failed++;
        end
        tick();
        resp_ready = '0;
        tests_run++;
        if (resp_valid !== '0 || req_ready !== 4'b0001) begin
            $display("FAIL bp_after: valid=%b ready=%b want 0000/0001", resp_valid, req_ready);
            tests_failed++;
        end
        tick();
        req_valid = '0;
        tests_run++;
        if (busy !== 1'b1 || alu_a !== a0) begin
            $display("FAIL bp_next_accept: busy=%b alu_a=%h want 1/%h", busy, alu_a, a0);
            tests_failed++;
        end
        resp_ready = '1;
        wait_idle();
        resp_ready = '0;
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] a0, b0;
        int n;
        a0 = 7'($urandom);
        b0 = 7'($urandom);
        req_a[0 +: WIDTH] = a0;
        req_b[0 +: WIDTH] = b0;
        req_sub[0] = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || resp_valid !== '0 || alu_a !== '0 || alu_b !== '0) begin
            $display("FAIL rstmid_state: busy=%b valid=%b alu_a=%h alu_b=%h want 0", busy, resp_valid,
                     alu_a, alu_b);
            tests_failed++;
        end
        rst = 1'b0;
        req_valid = 4'b1001;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL rstmid_first: got %b want 0001", req_ready);
            tests_failed++;
        end
        tick();
        req_valid = '0;
        wait_resp(n);
        tests_run++;
        if (resp_valid !== 4'b0001 || resp_q !== fake_add(a0, b0)) begin
            $display("FAIL rstmid_result: valid=%b q=%h want 0001/%h", resp_valid, resp_q, fake_add(a0, b0));
            tests_failed++;
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_random();
        int last, exp_id, n, d;
        logic [WIDTH-1:0] ea, eb, eq;
        logic [NREQ-1:0] mask;
        do_reset();
        last = NREQ - 1;
        for (int t = 0; t < 30; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*WIDTH +: WIDTH] = 7'($urandom);
                req_b[i*WIDTH +: WIDTH] = 7'($urandom);
                req_sub[i] = 1'($urandom);
            end
            req_valid = mask;
            #1;
            exp_id = -1;
            for (int k = 1; k <= NREQ; k++)
                if (exp_id < 0 && mask[(last + k) % NREQ]) exp_id = (last + k) % NREQ;
            ea = req_a[exp_id*WIDTH +: WIDTH];
            eb = req_sub[exp_id] ? model_neg(req_b[exp_id*WIDTH +: WIDTH]) : req_b[exp_id*WIDTH +: WIDTH];
            eq = fake_add(ea, eb);
            tests_run++;
            if (req_ready !== 4'(1 << exp_id)) begin
                $display("FAIL rand_grant[%0d]: got %b want id %0d", t, req_ready, exp_id);
                tests_failed++;
            end
            tick();
            req_a = 28'($urandom);
            req_b = 28'($urandom);
            req_sub = 4'($urandom);
            req_valid = 4'($urandom);
            #1;
            tests_run++;
            if (alu_a !== ea || alu_b !== eb) begin
                $display("FAIL rand_operands[%0d]: alu_a=%h alu_b=%h want %h/%h", t, alu_a, alu_b, ea, eb);
                tests_failed++;
            end
            wait_resp(n);
            tests_run++;
            if (n !== ALU_LAT) begin
                $display("FAIL rand_latency[%0d]: got %0d want %0d", t, n, ALU_LAT);
                tests_failed++;
            end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
                resp_ready = ~(4'(1 << exp_id));
                tick();
            end
            tests_run++;
            if (resp_valid !== 4'(1 << exp_id) || resp_q !== eq) begin
                $display("FAIL rand_result[%0d]: valid=%b q=%h want id %0d q %h", t, resp_valid, resp_q,
                         exp_id, eq);
                tests_failed++;
            end
            resp_ready = 4'(1 << exp_id);
            tick();
            resp_ready = '0;
            tests_run++;
            if (resp_valid !== '0) begin
                $display("FAIL rand_release[%0d]: got %b want 0000", t, resp_valid);
                tests_failed++;
            end
            last = exp_id;
        end
        req_valid = '0;
        resp_ready = '1;
        wait_idle();
        resp_ready = '0;
    endtask

`ifdef POSIT_ARB_PERF_EN
    task automatic test_perf();
        int acc, c;
        do_reset();
        req_valid = 4'b0010;
        resp_ready = '1;
        acc = 0;
        c = 0;
        #1;
        while (acc < 3 && c < 40) begin
            if (req_valid[1] && req_ready[1]) acc++;
            tick();
            c++;
        end
        req_valid = '0;
        wait_idle();
        resp_ready = '0;
        tests_run++;
        if (perf_grants !== 64'h0000_0000_0003_0000) begin
            $display("FAIL perf_counts: got %h want 0000000000030000", perf_grants);
            tests_failed++;
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_sub_negation();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef POSIT_ARB_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
